// File: rtl/acc_job_ctrl.sv
// acc_job_ctrl: job sequencer for one acc accumulator.
// Takes a command, runs acc for len cycles, returns the final sum.
module acc_job_ctrl #(
  parameter int NB_IDATA = 3,
  parameter int NB_ODATA = 6,
  parameter int NB_SEL   = 2,
  parameter int NB_LEN   = 4,
  parameter int ACC_LAT  = 1,
  parameter logic [NB_SEL-1:0] SEL_HOLD = 2'b11
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_clr,
  input  logic [NB_SEL-1:0]   i_cmd_sel,
  input  logic [NB_IDATA-1:0] i_cmd_data1,
  input  logic [NB_IDATA-1:0] i_cmd_data2,
  input  logic [NB_LEN-1:0]   i_cmd_len,
  output logic [NB_IDATA-1:0] o_acc_data1,
  output logic [NB_IDATA-1:0] o_acc_data2,
  output logic [NB_SEL-1:0]   o_acc_sel,
  output logic                o_acc_rst_n,
  input  logic [NB_ODATA-1:0] i_acc_data,
  input  logic                i_acc_overflow,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [NB_ODATA-1:0] o_res_data,
  output logic                o_res_overflow,
  output logic                o_busy
);

  localparam int NB_LAT = (ACC_LAT < 2) ? 1 : $clog2(ACC_LAT + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_nxt;
  logic                w_go;
  logic                w_cap;
  logic [NB_SEL-1:0]   r_sel;
  logic [NB_IDATA-1:0] r_d1;
  logic [NB_IDATA-1:0] r_d2;
  logic [NB_LEN-1:0]   r_len;
  logic [NB_LEN-1:0]   r_cnt;
  logic [NB_LAT-1:0]   r_lat;
  logic                r_ovf;
  logic [NB_SEL-1:0]   w_sel;
  logic [NB_IDATA-1:0] w_d1;
  logic [NB_IDATA-1:0] w_d2;

  logic                r_cmd_ready;
  logic                r_acc_rst_n;
  logic [NB_SEL-1:0]   r_acc_sel;
  logic [NB_IDATA-1:0] r_acc_d1;
  logic [NB_IDATA-1:0] r_acc_d2;
  logic                r_res_valid;
  logic [NB_ODATA-1:0] r_res_data;
  logic                r_res_ovf;
  logic                r_busy;

  assign w_go  = (r_state == ST_IDLE) && i_cmd_valid && r_cmd_ready;
  assign w_cap = (r_state == ST_DRAIN) && (r_lat == NB_LAT'(1));
  assign w_sel = w_go ? i_cmd_sel   : r_sel;
  assign w_d1  = w_go ? i_cmd_data1 : r_d1;
  assign w_d2  = w_go ? i_cmd_data2 : r_d2;

  // Next-state decode for the job sequence.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          if (i_cmd_clr)
            w_nxt = ST_CLR;
          else if (i_cmd_len != '0)
            w_nxt = ST_RUN;
          else
            w_nxt = ST_DRAIN;
        end
      end
      ST_CLR:
        w_nxt = (r_len != '0) ? ST_RUN : ST_DRAIN;
      ST_RUN:
        if (r_cnt == NB_LEN'(1)) w_nxt = ST_DRAIN;
      ST_DRAIN:
        if (r_lat == NB_LAT'(1)) w_nxt = ST_RESP;
      ST_RESP:
        if (i_res_ready) w_nxt = ST_IDLE;
      default:
        w_nxt = ST_IDLE;
    endcase
  end

  // State, job fields latched at transfer, and the run/drain counters.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_go) begin
        r_sel <= i_cmd_sel;
        r_d1  <= i_cmd_data1;
        r_d2  <= i_cmd_data2;
        r_len <= i_cmd_len;
        r_cnt <= i_cmd_len;
        r_lat <= NB_LAT'(ACC_LAT);
      end else begin
        if (r_state == ST_RUN)   r_cnt <= r_cnt - NB_LEN'(1);
        if (r_state == ST_DRAIN) r_lat <= r_lat - NB_LAT'(1);
      end
    end
  end

  // Sticky overflow across the job, then result capture at end of drain.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf      <= 1'b0;
      r_res_data <= '0;
      r_res_ovf  <= 1'b0;
    end else begin
      if (w_go)
        r_ovf <= 1'b0;
      else if (r_state == ST_RUN || r_state == ST_DRAIN)
        r_ovf <= r_ovf | i_acc_overflow;
      if (w_cap) begin
        r_res_data <= i_acc_data;
        r_res_ovf  <= r_ovf | i_acc_overflow;
      end
    end
  end

  // Registered outputs decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_ready <= 1'b0;
      r_acc_rst_n <= 1'b0;
      r_acc_sel   <= SEL_HOLD;
      r_acc_d1    <= '0;
      r_acc_d2    <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd_ready <= (w_nxt == ST_IDLE);
      r_acc_rst_n <= (w_nxt != ST_CLR);
      r_res_valid <= (w_nxt == ST_RESP);
      r_busy      <= (w_nxt != ST_IDLE);
      if (w_nxt == ST_RUN) begin
        r_acc_sel <= w_sel;
        r_acc_d1  <= w_d1;
        r_acc_d2  <= w_d2;
      end else begin
        r_acc_sel <= SEL_HOLD;
        r_acc_d1  <= '0;
        r_acc_d2  <= '0;
      end
    end
  end

  assign o_cmd_ready    = r_cmd_ready;
  assign o_acc_rst_n    = r_acc_rst_n;
  assign o_acc_sel      = r_acc_sel;
  assign o_acc_data1    = r_acc_d1;
  assign o_acc_data2    = r_acc_d2;
  assign o_res_valid    = r_res_valid;
  assign o_res_data     = r_res_data;
  assign o_res_overflow = r_res_ovf;
  assign o_busy         = r_busy;

endmodule
